// File: rtl/avalon_reg_arb_pkg.sv
// Shared types for the Avalon register arbiter: per-read tag carried down the
// latency pipeline so returning data can be steered to the requester that issued it.
package avalon_reg_arb_pkg;

    localparam int MAX_MASTERS = 8;
    localparam int MAX_IDWIDTH = 3;

    typedef struct packed {
        logic                   valid;
        logic [MAX_IDWIDTH-1:0] id;
    } tag_t;

endpackage

// File: rtl/avalon_register_arbiter_rr_arbiter.sv
// Combinational round-robin picker: scans upward from the pointer, wrapping,
// and grants the first active request.
module rr_arbiter #(
    parameter int MASTERS = 2,
    parameter int IDWIDTH = 1
) (
    input  logic [MASTERS-1:0] request,
    input  logic [IDWIDTH-1:0] pointer,
    output logic [MASTERS-1:0] grant,
    output logic [IDWIDTH-1:0] grant_id,
    output logic               grant_valid
);

    always_comb begin
        int idx;
        grant       = '0;
        grant_id    = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int k = 0; k < MASTERS; k++) begin
            idx = (int'(pointer) + k) % MASTERS;
            if (!grant_valid && request[idx]) begin
                grant[idx]  = 1'b1;
                grant_id    = IDWIDTH'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/avalon_register_arbiter.sv
// Round-robin arbiter sharing one register-adapter command port between MASTERS
// requesters. Define AVALON_REG_ARB_LOCK_EN to add the m_lock grant-hold port.
module avalon_register_arbiter
    import avalon_reg_arb_pkg::*;
#(
    parameter int MASTERS      = 2,
    parameter int REGS         = 1,
    parameter int LATENCY      = 1,
    parameter int ADDRESSWIDTH = (REGS > 1) ? $clog2(REGS) : 1,
    parameter int IDWIDTH      = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [MASTERS-1:0]                     m_read,
    input  logic [MASTERS-1:0]                     m_write,
    input  logic [MASTERS-1:0][ADDRESSWIDTH-1:0]   m_address,
    input  logic [MASTERS-1:0][31:0]               m_data_in,
`ifdef AVALON_REG_ARB_LOCK_EN
    input  logic [MASTERS-1:0]                     m_lock,
`endif
    output logic [MASTERS-1:0]                     m_waitrequest,
    output logic [MASTERS-1:0]                     m_read_valid,
    output logic [31:0]                            m_data_out,
    output logic                                   s_read,
    output logic                                   s_write,
    output logic [ADDRESSWIDTH-1:0]                s_address,
    output logic [31:0]                            s_data_in,
    input  logic                                   s_read_valid,
    input  logic [31:0]                            s_data_out
);

    logic [MASTERS-1:0] request;
    logic [MASTERS-1:0] eligible;
    logic [MASTERS-1:0] grant;
    logic [IDWIDTH-1:0] grant_id;
    logic               grant_valid;
    logic [IDWIDTH-1:0] rr_ptr;
    logic [IDWIDTH-1:0] next_ptr;
    logic               hold_ptr;
    tag_t               tag_pipe [LATENCY];
    tag_t               tag_tail;

    assign request = m_read | m_write;

`ifdef AVALON_REG_ARB_LOCK_EN
    logic               locked;
    logic [IDWIDTH-1:0] owner;

    // While locked only the owner may win; the pointer stays put until the
    // owner's unlocking transfer.
    always_comb begin
        eligible = request;
        if (locked) begin
            eligible        = '0;
            eligible[owner] = request[owner];
        end
    end

    assign hold_ptr = locked && grant_valid && m_lock[grant_id];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            locked <= 1'b0;
            owner  <= '0;
        end else if (grant_valid) begin
            locked <= m_lock[grant_id];
            owner  <= grant_id;
        end
    end
`else
    assign eligible = request;
    assign hold_ptr = 1'b0;
`endif

    rr_arbiter #(
        .MASTERS (MASTERS),
        .IDWIDTH (IDWIDTH)
    ) u_rr_arbiter (
        .request     (eligible),
        .pointer     (rr_ptr),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    always_comb begin
        next_ptr = rr_ptr;
        if (grant_valid && !hold_ptr) begin
            if (grant_id == IDWIDTH'(MASTERS - 1))
                next_ptr = '0;
            else
                next_ptr = grant_id + IDWIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rr_ptr <= '0;
        else
            rr_ptr <= next_ptr;
    end

    always_comb begin
        s_read    = 1'b0;
        s_write   = 1'b0;
        s_address = '0;
        s_data_in = '0;
        if (grant_valid) begin
            s_read    = m_read[grant_id];
            s_write   = m_write[grant_id];
            s_address = m_address[grant_id];
            s_data_in = m_data_in[grant_id];
        end
    end

    // Idle requesters never see a stall; during reset everyone is held off.
    assign m_waitrequest = reset ? '1 : (request & ~grant);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < LATENCY; k++)
                tag_pipe[k] <= '0;
        end else begin
            tag_pipe[0] <= '{valid: s_read, id: MAX_IDWIDTH'(grant_id)};
            for (int k = 1; k < LATENCY; k++)
                tag_pipe[k] <= tag_pipe[k-1];
        end
    end

    assign tag_tail = tag_pipe[LATENCY-1];

    always_comb begin
        m_read_valid = '0;
        for (int i = 0; i < MASTERS; i++)
            m_read_valid[i] = s_read_valid && tag_tail.valid && (tag_tail.id == MAX_IDWIDTH'(i));
    end

    assign m_data_out = s_data_out;

    assert property (@(posedge clk) disable iff (reset) (m_read & m_write) == '0);
    assert property (@(posedge clk) disable iff (reset) s_read_valid |-> tag_tail.valid);

endmodule

// File: tb/tb_avalon_register_arbiter.sv
// Directed bench: dut_a is 2 requesters / latency 1, dut_b is 3 requesters / latency 3,
// each backed by a small register-adapter model returning 0xA5A5_0000 | address.
module tb_avalon_register_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   nChecks = 0;
    int   nFails  = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] regval(input logic [7:0] addr);
        return 32'hA5A5_0000 | {24'h0, addr};
    endfunction

    // dut_a: MASTERS=2, REGS=4, LATENCY=1
    logic [1:0]       a_read = '0, a_write = '0, a_lock = '0;
    logic [1:0][1:0]  a_address = '0;
    logic [1:0][31:0] a_data_in = '0;
    logic [1:0]       a_wait, a_rvalid;
    logic [31:0]      a_dout, a_s_data_in, a_s_dout;
    logic             a_s_read, a_s_write, a_s_rvalid;
    logic [1:0]       a_s_address;

    avalon_register_arbiter #(.MASTERS(2), .REGS(4), .LATENCY(1)) dut_a (
        .clk           (clk),
        .reset         (reset),
        .m_read        (a_read),
        .m_write       (a_write),
        .m_address     (a_address),
        .m_data_in     (a_data_in),
`ifdef AVALON_REG_ARB_LOCK_EN
        .m_lock        (a_lock),
`endif
        .m_waitrequest (a_wait),
        .m_read_valid  (a_rvalid),
        .m_data_out    (a_dout),
        .s_read        (a_s_read),
        .s_write       (a_s_write),
        .s_address     (a_s_address),
        .s_data_in     (a_s_data_in),
        .s_read_valid  (a_s_rvalid),
        .s_data_out    (a_s_dout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_s_rvalid <= 1'b0;
            a_s_dout   <= '0;
        end else begin
            a_s_rvalid <= a_s_read;
            a_s_dout   <= regval({6'h0, a_s_address});
        end
    end

    // dut_b: MASTERS=3, REGS=8, LATENCY=3
    logic [2:0]       b_read = '0, b_write = '0;
    logic [2:0][2:0]  b_address = '0;
    logic [2:0][31:0] b_data_in;
    logic [2:0]       b_wait, b_rvalid;
    logic [31:0]      b_dout, b_s_data_in;
    logic             b_s_read, b_s_write;
    logic [2:0]       b_s_address;
    logic [2:0]       b_rv;
    logic [2:0][2:0]  b_ad;

    assign b_data_in = {32'hB0B0_0002, 32'hB0B0_0001, 32'hB0B0_0000};

    avalon_register_arbiter #(.MASTERS(3), .REGS(8), .LATENCY(3)) dut_b (
        .clk           (clk),
        .reset         (reset),
        .m_read        (b_read),
        .m_write       (b_write),
        .m_address     (b_address),
        .m_data_in     (b_data_in),
`ifdef AVALON_REG_ARB_LOCK_EN
        .m_lock        (3'b000),
`endif
        .m_waitrequest (b_wait),
        .m_read_valid  (b_rvalid),
        .m_data_out    (b_dout),
        .s_read        (b_s_read),
        .s_write       (b_s_write),
        .s_address     (b_s_address),
        .s_data_in     (b_s_data_in),
        .s_read_valid  (b_rv[2]),
        .s_data_out    (regval({5'h0, b_ad[2]}))
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            b_rv <= '0;
            b_ad <= '0;
        end else begin
            b_rv <= {b_rv[1:0], b_s_read};
            b_ad <= {b_ad[1:0], b_s_address};
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] rd, input logic [1:0] wr,
                                 input logic [1:0] ad0, input logic [1:0] ad1,
                                 input logic [31:0] d0, input logic [31:0] d1,
                                 input logic [1:0] lk);
        @(posedge clk);
        #1;
        a_read       = rd;
        a_write      = wr;
        a_address[0] = ad0;
        a_address[1] = ad1;
        a_data_in[0] = d0;
        a_data_in[1] = d1;
        a_lock       = lk;
        #3;
    endtask

    task automatic applyStimulusB(input logic [2:0] rd, input logic [2:0] wr,
                                  input logic [2:0] ad0, input logic [2:0] ad1, input logic [2:0] ad2);
        @(posedge clk);
        #1;
        b_read       = rd;
        b_write      = wr;
        b_address[0] = ad0;
        b_address[1] = ad1;
        b_address[2] = ad2;
        #3;
    endtask

    initial begin
        #3;
        checkOutput("reset_a_wait", a_wait, 2'b11);
        checkOutput("reset_b_wait", b_wait, 3'b111);
        checkOutput("reset_a_sread", a_s_read, 0);
        checkOutput("reset_a_swrite", a_s_write, 0);
        checkOutput("reset_a_rvalid", a_rvalid, 0);
        checkOutput("reset_a_dout", a_dout, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        #3;
        checkOutput("idle_a_wait", a_wait, 2'b00);
        checkOutput("idle_b_wait", b_wait, 3'b000);

        // Single reads through the latency-1 path
        applyStimulus(2'b01, 2'b00, 2'd3, 2'd0, 0, 0, 2'b00);
        checkOutput("rd0_sread", a_s_read, 1);
        checkOutput("rd0_saddr", a_s_address, 3);
        checkOutput("rd0_wait", a_wait, 2'b00);
        applyStimulus(2'b00, 2'b00, 2'd0, 2'd0, 0, 0, 2'b00);
        checkOutput("rd0_rvalid", a_rvalid, 2'b01);
        checkOutput("rd0_dout", a_dout, 32'hA5A5_0003);
        applyStimulus(2'b10, 2'b00, 2'd0, 2'd2, 0, 0, 2'b00);
        checkOutput("rd1_saddr", a_s_address, 2);
        checkOutput("rd1_wait", a_wait, 2'b00);
        applyStimulus(2'b00, 2'b00, 2'd0, 2'd0, 0, 0, 2'b00);
        checkOutput("rd1_rvalid", a_rvalid, 2'b10);
        checkOutput("rd1_dout", a_dout, 32'hA5A5_0002);

        // Contested writes alternate starting from requester 0
        for (int k = 0; k < 4; k++) begin
            applyStimulus(2'b00, 2'b11, 2'd1, 2'd2, 32'h1111_1111, 32'h2222_2222, 2'b00);
            checkOutput($sformatf("wr%0d_wait", k), a_wait, (k % 2 == 0) ? 2'b10 : 2'b01);
            checkOutput($sformatf("wr%0d_swrite", k), a_s_write, 1);
            checkOutput($sformatf("wr%0d_saddr", k), a_s_address, (k % 2 == 0) ? 2'd1 : 2'd2);
            checkOutput($sformatf("wr%0d_sdata", k), a_s_data_in,
                        (k % 2 == 0) ? 32'h1111_1111 : 32'h2222_2222);
        end

        // Back-to-back reads from both requesters
        applyStimulus(2'b11, 2'b00, 2'd0, 2'd1, 0, 0, 2'b00);
        checkOutput("pipe_c0_wait", a_wait, 2'b10);
        checkOutput("pipe_c0_saddr", a_s_address, 0);
        checkOutput("pipe_c0_rvalid", a_rvalid, 2'b00);
        applyStimulus(2'b10, 2'b00, 2'd0, 2'd1, 0, 0, 2'b00);
        checkOutput("pipe_c1_wait", a_wait, 2'b00);
        checkOutput("pipe_c1_saddr", a_s_address, 1);
        checkOutput("pipe_c1_rvalid", a_rvalid, 2'b01);
        checkOutput("pipe_c1_dout", a_dout, 32'hA5A5_0000);
        applyStimulus(2'b00, 2'b00, 2'd0, 2'd0, 0, 0, 2'b00);
        checkOutput("pipe_c2_rvalid", a_rvalid, 2'b10);
        checkOutput("pipe_c2_dout", a_dout, 32'hA5A5_0001);

`ifdef AVALON_REG_ARB_LOCK_EN
        // Requester 1 locks; requester 0 waits until the unlocking transfer
        applyStimulus(2'b00, 2'b11, 2'd0, 2'd1, 0, 0, 2'b10);
        checkOutput("lock_c0_wait", a_wait, 2'b10);
        applyStimulus(2'b00, 2'b11, 2'd0, 2'd1, 0, 0, 2'b10);
        checkOutput("lock_c1_wait", a_wait, 2'b01);
        applyStimulus(2'b00, 2'b11, 2'd0, 2'd1, 0, 0, 2'b10);
        checkOutput("lock_c2_wait", a_wait, 2'b01);
        applyStimulus(2'b00, 2'b11, 2'd0, 2'd1, 0, 0, 2'b00);
        checkOutput("lock_c3_wait", a_wait, 2'b01);
        applyStimulus(2'b00, 2'b11, 2'd0, 2'd1, 0, 0, 2'b00);
        checkOutput("lock_c4_wait", a_wait, 2'b10);
`endif
        applyStimulus(2'b00, 2'b00, 2'd0, 2'd0, 0, 0, 2'b00);

        // Latency-3 reads from two requesters in consecutive cycles
        applyStimulusB(3'b001, 3'b000, 3'd5, 3'd0, 3'd0);
        checkOutput("l3_c0_wait", b_wait, 3'b000);
        checkOutput("l3_c0_saddr", b_s_address, 5);
        applyStimulusB(3'b010, 3'b000, 3'd0, 3'd6, 3'd0);
        checkOutput("l3_c1_saddr", b_s_address, 6);
        checkOutput("l3_c1_rvalid", b_rvalid, 3'b000);
        applyStimulusB(3'b000, 3'b000, 3'd0, 3'd0, 3'd0);
        checkOutput("l3_c2_rvalid", b_rvalid, 3'b000);
        applyStimulusB(3'b000, 3'b000, 3'd0, 3'd0, 3'd0);
        checkOutput("l3_c3_rvalid", b_rvalid, 3'b001);
        checkOutput("l3_c3_dout", b_dout, 32'hA5A5_0005);
        applyStimulusB(3'b000, 3'b000, 3'd0, 3'd0, 3'd0);
        checkOutput("l3_c4_rvalid", b_rvalid, 3'b010);
        checkOutput("l3_c4_dout", b_dout, 32'hA5A5_0006);
        applyStimulusB(3'b000, 3'b000, 3'd0, 3'd0, 3'd0);
        checkOutput("l3_c5_rvalid", b_rvalid, 3'b000);

        // Lone requester 2 is granted every cycle and wraps the pointer to 0
        for (int k = 0; k < 3; k++) begin
            applyStimulusB(3'b000, 3'b100, 3'd0, 3'd0, 3'd7);
            checkOutput($sformatf("m2_c%0d_wait", k), b_wait, 3'b000);
            checkOutput($sformatf("m2_c%0d_saddr", k), b_s_address, 7);
            checkOutput($sformatf("m2_c%0d_sdata", k), b_s_data_in, 32'hB0B0_0002);
        end
        applyStimulusB(3'b000, 3'b011, 3'd0, 3'd1, 3'd0);
        checkOutput("m2_after_wait", b_wait, 3'b010);
        applyStimulusB(3'b000, 3'b010, 3'd0, 3'd1, 3'd0);
        checkOutput("m2_after2_wait", b_wait, 3'b000);

        // Reset one cycle after a read discards the in-flight tag
        applyStimulusB(3'b001, 3'b000, 3'd4, 3'd0, 3'd0);
        checkOutput("rst_c0_sread", b_s_read, 1);
        @(posedge clk);
        #1;
        reset  = 1'b1;
        b_read = 3'b000;
        #3;
        checkOutput("rst_c1_wait", b_wait, 3'b111);
        checkOutput("rst_c1_rvalid", b_rvalid, 3'b000);
        @(posedge clk);
        #1 reset = 1'b0;
        #3;
        checkOutput("rst_c2_rvalid", b_rvalid, 3'b000);
        applyStimulusB(3'b011, 3'b000, 3'd1, 3'd2, 3'd0);
        checkOutput("rst_c3_wait", b_wait, 3'b010);
        checkOutput("rst_c3_rvalid", b_rvalid, 3'b000);
        applyStimulusB(3'b010, 3'b000, 3'd1, 3'd2, 3'd0);
        checkOutput("rst_c4_wait", b_wait, 3'b000);
        checkOutput("rst_c4_rvalid", b_rvalid, 3'b000);
        applyStimulusB(3'b000, 3'b000, 3'd0, 3'd0, 3'd0);
        checkOutput("rst_c5_rvalid", b_rvalid, 3'b000);
        applyStimulusB(3'b000, 3'b000, 3'd0, 3'd0, 3'd0);
        checkOutput("rst_c6_rvalid", b_rvalid, 3'b001);
        checkOutput("rst_c6_dout", b_dout, 32'hA5A5_0001);
        applyStimulusB(3'b000, 3'b000, 3'd0, 3'd0, 3'd0);
        checkOutput("rst_c7_rvalid", b_rvalid, 3'b010);
        checkOutput("rst_c7_dout", b_dout, 32'hA5A5_0002);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
